// File: rtl/kb_defs.sv
// kb_defs: shared constants, entry field positions and decoder state encodings
package kb_defs;
    localparam logic [7:0] KB_E0     = 8'hE0;
    localparam logic [7:0] KB_F0     = 8'hF0;
    localparam logic [7:0] KB_LSHIFT = 8'h12;
    localparam logic [7:0] KB_RSHIFT = 8'h59;
    localparam int EXT_BIT = 9;
    localparam int BRK_BIT = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK} kb_state_e;
endpackage

// File: rtl/kb_fifo.sv
// kb_fifo: synchronous first-word-fall-through FIFO, 2**ADDR_W entries
// Ports: wr/w_data push, rd pops head, r_data shows head (0 while empty), empty/full flags.
// Writes while full are taken only with a coincident read; reads while empty are ignored.
module kb_fifo #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W:0]   wptr_q, rptr_q;
    logic              do_wr, do_rd;

    assign empty  = wptr_q == rptr_q;
    assign full   = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) && (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign do_rd  = rd & ~empty;
    assign do_wr  = wr & (~full | rd);
    assign r_data = empty ? '0 : mem_q[rptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk)
        if (do_wr) mem_q[wptr_q[ADDR_W-1:0]] <= w_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_q + (ADDR_W+1)'(do_wr);
            rptr_q <= rptr_q + (ADDR_W+1)'(do_rd);
        end
endmodule

// File: rtl/kb_event_buf.sv
// kb_event_buf: folds PS/2 E0/F0 prefixes into {ext,brk,code} events, tracks shift, queues events in a FWFT FIFO
// Ports: clk, reset (async, active-high), scan_done_tick/scan_data byte input,
// rd_key pop, key_data head entry (0 while empty), empty, full, overflow (sticky), shift_on.
// Macro KB_BREAK_EVENTS_EN: when defined break events are queued; otherwise only make events are.
module kb_event_buf
    import kb_defs::*;
#(
    parameter int ADDR_W  = 3,
    parameter int TMO_CYC = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_data,
    input  logic       rd_key,
    output logic [9:0] key_data,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       shift_on
);
    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    kb_state_e     state_q, state_d;
    logic          ext_q, ext_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lshift_q, lshift_d, rshift_q, rshift_d, ovf_q, ovf_d;
    logic          emit, emit_ext, emit_brk, is_pfx, want_wr;
    logic [9:0]    event_w;

    assign is_pfx = (scan_data == KB_E0) || (scan_data == KB_F0);

    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        cnt_d    = '0;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (scan_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = (scan_data == KB_E0) ? ST_EXT : (scan_data == KB_F0) ? ST_BRK : ST_IDLE;
                    ext_d   = 1'b0;
                    emit    = ~is_pfx;
                end
                ST_EXT: begin
                    state_d  = (scan_data == KB_E0) ? ST_EXT : (scan_data == KB_F0) ? ST_BRK : ST_IDLE;
                    ext_d    = scan_data == KB_F0;
                    emit     = ~is_pfx;
                    emit_ext = 1'b1;
                end
                ST_BRK: begin
                    // a second prefix inside a break is a protocol error: drop it all
                    state_d  = ST_IDLE;
                    ext_d    = 1'b0;
                    emit     = ~is_pfx;
                    emit_ext = ext_q;
                    emit_brk = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // abandon a dangling prefix after a long idle gap
            state_d = (cnt_q == TMO_LAST) ? ST_IDLE : state_q;
            ext_d   = (cnt_q == TMO_LAST) ? 1'b0 : ext_q;
            cnt_d   = (cnt_q == TMO_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign lshift_d = (emit && !emit_ext && scan_data == KB_LSHIFT) ? ~emit_brk : lshift_q;
    assign rshift_d = (emit && !emit_ext && scan_data == KB_RSHIFT) ? ~emit_brk : rshift_q;
    assign event_w  = {emit_ext, emit_brk, scan_data};

`ifdef KB_BREAK_EVENTS_EN
    assign want_wr = emit;
`else
    assign want_wr = emit & ~emit_brk;
`endif

    assign ovf_d    = ovf_q | (want_wr & full & ~rd_key);
    assign overflow = ovf_q;
    assign shift_on = lshift_q | rshift_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q  <= ST_IDLE;
            ext_q    <= 1'b0;
            cnt_q    <= '0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            cnt_q    <= cnt_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            ovf_q    <= ovf_d;
        end

    kb_fifo #(.DATA_W(10), .ADDR_W(ADDR_W)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (want_wr),
        .rd     (rd_key),
        .w_data (event_w),
        .r_data (key_data),
        .empty  (empty),
        .full   (full)
    );
endmodule
